// File: rtl/adc_event_capture.sv
// ============================================================================
// adc_event_capture : circular pre-trigger ADC history, frame capture, streamed readout
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc_event_capture #(
  parameter int DATA_W     = 14,
  parameter int DEPTH_LOG2 = 10,
  parameter int PRE        = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ADC_IN,
  input  logic              trigger,
  input  logic              arm,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic [7:0]        missed_trig
);

  localparam int                    c_DEPTH   = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] c_PRE     = DEPTH_LOG2'(PRE);
  localparam logic [DEPTH_LOG2-1:0] c_POST    = DEPTH_LOG2'(c_DEPTH-PRE-1);
  localparam logic [DEPTH_LOG2:0]   c_NWORDS  = (DEPTH_LOG2+1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2:0]   c_LAST_RD = (DEPTH_LOG2+1)'(c_DEPTH-1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] fill_cnt_q, fill_cnt_d;
  logic [DEPTH_LOG2-1:0] post_cnt_q, post_cnt_d;
  logic [DEPTH_LOG2-1:0] rd_addr_q, rd_addr_d;
  logic [DEPTH_LOG2:0]   rd_cnt_q, rd_cnt_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  skid_last_q, skid_last_d;
  logic [DATA_W-1:0]     skid_data_q, skid_data_d;
  logic [7:0]            missed_q, missed_d;

  logic [DATA_W-1:0]     mem [c_DEPTH];
  logic [DATA_W-1:0]     ram_q;
  logic                  w_we, w_re, w_pop, w_free;
  logic [1:0]            w_occ;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    post_cnt_d   = post_cnt_q;
    rd_addr_d    = rd_addr_q;
    rd_cnt_d     = rd_cnt_q;
    pend_d       = 1'b0;
    pend_last_d  = pend_last_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    skid_data_d  = skid_data_q;
    missed_d     = missed_q;
    w_we         = 1'b0;
    w_re         = 1'b0;
    w_pop        = out_valid_q && rd_ready;
    w_free       = !out_valid_q || w_pop;
    // Words held or in flight after this cycle's pop; the read pipe never exceeds two.
    w_occ        = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q} - {1'b0, w_pop};

    if (trigger && state_q != S_ARMED && missed_q != 8'hFF) begin
      missed_d = missed_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_FILL;
          fill_cnt_d = '0;
        end
      end
      S_FILL: begin
        w_we       = 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == c_PRE - 1'b1) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        w_we     = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (trigger) begin
          rd_addr_d  = wr_ptr_q - c_PRE;
          rd_cnt_d   = '0;
          post_cnt_d = c_POST;
          state_d    = (c_POST == '0) ? S_READOUT : S_POST;
        end
      end
      S_POST: begin
        w_we       = 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        post_cnt_d = post_cnt_q - 1'b1;
        if (post_cnt_q == 1) begin
          state_d = S_READOUT;
        end
      end
      S_READOUT: begin
        if (rd_cnt_q != c_NWORDS && w_occ < 2'd2) begin
          w_re        = 1'b1;
          rd_addr_d   = rd_addr_q + 1'b1;
          rd_cnt_d    = rd_cnt_q + 1'b1;
          pend_d      = 1'b1;
          pend_last_d = (rd_cnt_q == c_LAST_RD);
        end
        // Ordered stages: out, skid, then the RAM word landing this cycle.
        if (w_free) begin
          if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = pend_q;
            skid_data_d  = ram_q;
            skid_last_d  = pend_last_q;
          end else if (pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_q;
            out_last_d  = pend_last_q;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end else if (pend_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = ram_q;
          skid_last_d  = pend_last_q;
        end
        if (w_pop && out_last_q) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      post_cnt_q   <= '0;
      rd_addr_q    <= '0;
      rd_cnt_q     <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
      missed_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      post_cnt_q   <= post_cnt_d;
      rd_addr_q    <= rd_addr_d;
      rd_cnt_q     <= rd_cnt_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
      missed_q     <= missed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[wr_ptr_q] <= ADC_IN;
    end
    if (w_re) begin
      ram_q <= mem[rd_addr_q];
    end
  end

  assign rd_data     = out_data_q;
  assign rd_valid    = out_valid_q;
  assign rd_last     = out_last_q;
  assign busy        = (state_q != S_IDLE);
  assign missed_trig = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_event_capture.sv
// ============================================================================
// tb_adc_event_capture : directed self-checking bench for adc_event_capture
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adc_event_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] adc_in = '0;
  logic        trigger = 1'b0;
  logic        arm = 1'b0;
  logic        rd_ready = 1'b0;
  logic [13:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        busy;
  logic [7:0]  missed_trig;

  int errors = 0;
  int checks = 0;

  adc_event_capture #(
    .DATA_W    (14),
    .DEPTH_LOG2(4),
    .PRE       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ADC_IN     (adc_in),
    .trigger    (trigger),
    .arm        (arm),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .busy       (busy),
    .missed_trig(missed_trig)
  );

  always #5 clk = ~clk;

  // One clock: inputs change 1 time unit after the edge, ramp advances by one.
  task automatic cyc();
    @(posedge clk);
    #1;
    adc_in = adc_in + 14'd1;
  endtask

  // Arm with ADC_IN=0, pulse trigger at every ramp value set in tmask, then
  // receive n_words of the frame and check them against first_val onwards.
  task automatic run_frame(input string name, input logic [63:0] tmask, input int trig_val,
                           input int first_val, input bit toggled, input int n_words);
    int          idx, cyc_n, phase, first_cyc, last_cyc;
    bit          stalled, seen;
    logic [13:0] held_d, exp_d;
    logic        held_l, exp_l;
    idx = 0; cyc_n = 0; phase = 0; first_cyc = 0; last_cyc = 0;
    stalled = 0; seen = 0; held_d = '0; held_l = 1'b0;
    adc_in = '0;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    while (idx < n_words && cyc_n < 400) begin
      trigger  = (adc_in < 14'd64) ? tmask[adc_in[5:0]] : 1'b0;
      rd_ready = toggled ? ((phase % 4) == 0 || (phase % 4) == 3) : 1'b1;
      phase++;
      if (stalled) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== held_d || rd_last !== held_l) begin
          errors++;
          $display("FAIL %s stall_hold: got valid=%b data=%0d last=%b, need valid=1 data=%0d last=%b",
                   name, rd_valid, rd_data, rd_last, held_d, held_l);
        end
      end
      stalled = 0;
      if (rd_valid === 1'b1 && !seen) begin
        seen = 1;
        checks++;
        if (adc_in > 14'(trig_val + 15)) begin
          errors++;
          $display("FAIL %s first_valid_latency: first valid at ramp %0d, need <= %0d",
                   name, adc_in, trig_val + 15);
        end
      end
      if (rd_valid === 1'b1 && rd_ready) begin
        exp_d = 14'(first_val + idx);
        exp_l = (idx == 15);
        checks++;
        if (rd_data !== exp_d) begin
          errors++;
          $display("FAIL %s word%0d_data: got %0d, need %0d", name, idx, rd_data, exp_d);
        end
        checks++;
        if (rd_last !== exp_l) begin
          errors++;
          $display("FAIL %s word%0d_last: got %b, need %b", name, idx, rd_last, exp_l);
        end
        if (idx == 0) first_cyc = cyc_n;
        last_cyc = cyc_n;
        idx++;
      end else if (rd_valid === 1'b1) begin
        stalled = 1;
        held_d  = rd_data;
        held_l  = rd_last;
      end
      cyc();
      cyc_n++;
    end
    trigger  = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (idx != n_words) begin
      errors++;
      $display("FAIL %s timeout: got %0d words, need %0d", name, idx, n_words);
    end
    if (n_words == 16) begin
      checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s end_state: got busy=%b valid=%b, need busy=0 valid=0", name, busy, rd_valid);
      end
      if (!toggled) begin
        checks++;
        if (last_cyc - first_cyc != 15) begin
          errors++;
          $display("FAIL %s throughput: got span %0d cycles, need 15", name, last_cyc - first_cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if (rd_data !== 14'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || busy !== 1'b0 || missed_trig !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: got data=%0d valid=%b last=%b busy=%b missed=%0d, need all 0",
               rd_data, rd_valid, rd_last, busy, missed_trig);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_trigger();
    for (int i = 0; i < 10; i++) cyc();
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || missed_trig !== 8'd1) begin
      errors++;
      $display("FAIL idle_trigger: got busy=%b valid=%b missed=%0d, need busy=0 valid=0 missed=1",
               busy, rd_valid, missed_trig);
    end
  endtask

  task automatic test_full_rate();
    run_frame("full_rate", 64'd1 << 20, 20, 16, 1'b0, 16);
  endtask

  task automatic test_back_to_back();
    run_frame("backpressure", 64'd1 << 20, 20, 16, 1'b1, 16);
  endtask

  task automatic test_wrap();
    run_frame("wrap", 64'd1 << 50, 50, 46, 1'b0, 16);
  endtask

  task automatic test_missed();
    logic [63:0] m;
    test_reset();
    m = (64'd1 << 2) | (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 14) | (64'd1 << 16);
    run_frame("missed", m, 10, 6, 1'b0, 16);
    checks++;
    if (missed_trig !== 8'd4) begin
      errors++;
      $display("FAIL missed_count: got %0d, need 4", missed_trig);
    end
  endtask

  task automatic test_reset_mid_readout();
    run_frame("pre_reset", 64'd1 << 20, 20, 16, 1'b0, 5);
    rst_n = 1'b0;
    cyc();
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || missed_trig !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b busy=%b missed=%0d, need 0 0 0", rd_valid, busy, missed_trig);
    end
    rst_n = 1'b1;
    run_frame("post_reset", 64'd1 << 20, 20, 16, 1'b0, 16);
  endtask

  task automatic test_saturate();
    trigger = 1'b1;
    for (int i = 0; i < 260; i++) cyc();
    trigger = 1'b0;
    cyc();
    checks++;
    if (missed_trig !== 8'd255) begin
      errors++;
      $display("FAIL missed_saturate: got %0d, need 255", missed_trig);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_trigger();
    test_full_rate();
    test_back_to_back();
    test_wrap();
    test_missed();
    test_reset_mid_readout();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
